// File: rtl/eq_nband_tdm.sv
// N-band, T-tap FIR graphic equalizer sharing one multiply-accumulate datapath across all bands.
// Optional EQ_ROUND_EN: round-half-up on both scaling shifts instead of truncation.
module eq_nband_tdm #(
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int GW     = 16,
    parameter int GFRAC  = 12,
    parameter int NBANDS = 8,
    parameter int NTAPS  = 16,
    localparam int BW    = (NBANDS > 1) ? $clog2(NBANDS) : 1,
    localparam int TPW   = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        x,
    input  logic [NBANDS*GW-1:0] gain,
    input  logic                 coef_we,
    input  logic [BW-1:0]        coef_band,
    input  logic [TPW-1:0]       coef_tap,
    input  logic [CW-1:0]        coef_data,
    output logic                 out_valid,
    output logic [DW-1:0]        y,
    output logic                 sat
);

    localparam int AW = DW + CW + TPW;
    localparam int TW = AW + GW + BW + 1;

    localparam logic signed [TW-1:0] Y_MAX = {{(TW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [TW-1:0] Y_MIN = {{(TW-DW+1){1'b1}}, {(DW-1){1'b0}}};

`ifdef EQ_ROUND_EN
    localparam logic signed [AW-1:0] ACC_RND  = {{(AW-1){1'b0}}, 1'b1} << (CW-2);
    localparam logic signed [TW-1:0] GAIN_RND = {{(TW-1){1'b0}}, 1'b1} << (GFRAC-1);
`else
    localparam logic signed [AW-1:0] ACC_RND  = '0;
    localparam logic signed [TW-1:0] GAIN_RND = '0;
`endif

    typedef enum logic [1:0] {StIdle, StMac, StGain, StOut} state_e;

    state_e                 state_q;
    logic signed [DW-1:0]   dl_q   [NTAPS];
    logic signed [CW-1:0]   coef_q [NBANDS][NTAPS];
    logic signed [GW-1:0]   gain_q [NBANDS];
    logic signed [AW-1:0]   acc_q;
    logic signed [TW-1:0]   total_q;
    logic [BW-1:0]          b_q;
    logic [TPW-1:0]         t_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [DW-1:0]          y_q;
    logic                   sat_q;

    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    band_val;
    logic signed [TW-1:0]    gprod;
    logic signed [TW-1:0]    scaled;
    logic                    coef_wr;

    always_comb begin
        prod     = coef_q[b_q][t_q] * dl_q[t_q];
        band_val = (acc_q + ACC_RND) >>> (CW-1);
        gprod    = TW'(band_val) * TW'(gain_q[b_q]);
        scaled   = (gprod + GAIN_RND) >>> GFRAC;
        coef_wr  = in_ready_q && coef_we && (int'(coef_band) < NBANDS)
                   && (int'(coef_tap) < NTAPS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            total_q     <= '0;
            b_q         <= '0;
            t_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
            for (int k = 0; k < NTAPS; k++) dl_q[k] <= '0;
            for (int i = 0; i < NBANDS; i++) begin
                gain_q[i] <= '0;
                for (int k = 0; k < NTAPS; k++) coef_q[i][k] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            // Writes land on this edge, so a same-cycle acceptance already sees them in MAC.
            if (coef_wr) coef_q[coef_band][coef_tap] <= coef_data;

            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        for (int k = NTAPS-1; k > 0; k--) dl_q[k] <= dl_q[k-1];
                        dl_q[0] <= x;
                        for (int i = 0; i < NBANDS; i++) gain_q[i] <= gain[i*GW +: GW];
                        acc_q      <= '0;
                        total_q    <= '0;
                        b_q        <= '0;
                        t_q        <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StMac;
                    end
                end
                StMac: begin
                    acc_q <= acc_q + AW'(prod);
                    if (t_q == TPW'(NTAPS-1)) state_q <= StGain;
                    else                      t_q     <= t_q + TPW'(1);
                end
                StGain: begin
                    total_q <= total_q + scaled;
                    if (b_q == BW'(NBANDS-1)) begin
                        state_q <= StOut;
                    end else begin
                        b_q     <= b_q + BW'(1);
                        t_q     <= '0;
                        acc_q   <= '0;
                        state_q <= StMac;
                    end
                end
                StOut: begin
                    if (total_q > Y_MAX) begin
                        y_q   <= Y_MAX[DW-1:0];
                        sat_q <= 1'b1;
                    end else if (total_q < Y_MIN) begin
                        y_q   <= Y_MIN[DW-1:0];
                        sat_q <= 1'b1;
                    end else begin
                        y_q   <= total_q[DW-1:0];
                        sat_q <= 1'b0;
                    end
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign sat       = sat_q;

endmodule

// File: doc/eq_nband_tdm.md
# eq_nband_tdm

Parametrised N-band, T-tap FIR graphic equalizer that time-multiplexes one multiply-accumulate datapath across all bands and taps. Each accepted input sample goes through a shared delay line and NBANDS runtime-loadable FIR coefficient sets. Each band result is scaled by its gain, all bands are summed, and the sum is saturated to one output sample. The block sits between the sample source and the output stage, in place of the fixed 8-band filter/gain/adder chain.

## Interface

- DW, 16: sample width, signed Q1.(DW-1)
- CW, 16: coefficient width, signed Q1.(CW-1)
- GW, 16: gain width, signed
- GFRAC, 12: gain fractional bits (0x1000 = 1.0 at default)
- NBANDS, 8: number of bands, ≥1
- NTAPS, 16: taps per band, ≥2
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  x is valid
- in_ready  out  1  block is idle and can accept a sample
- x  in  DW  input sample
- gain  in  NBANDS×GW  per-band gains, sampled on acceptance
- coef_we  in  1  coefficient write strobe
- coef_band  in  clog2(NBANDS)  band index of the write
- coef_tap  in  clog2(NTAPS)  tap index of the write
- coef_data  in  CW  coefficient value
- out_valid  out  1  one-cycle pulse; y is valid
- y  out  DW  equalized sample, held until the next out_valid
- sat  out  1  y was clamped; updated together with y

## Operation

- States: IDLE, MAC, GAIN, OUT. Reset enters IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: shift x into dl[0] (dl[k]←dl[k-1]), latch all gains, clear total, set b=0, t=0, go to MAC.
- MAC: acc += coef[b][t]*dl[t].
  - acc is signed, width DW+CW+clog2(NTAPS).
  - acc is cleared on entry to each band.
  - t increments; after t=NTAPS-1, go to GAIN.
- GAIN:
  - band = acc>>>(CW-1).
  - total += (band*gain_l[b])>>>GFRAC, where total is signed and wide enough that it never wraps.
  - If b<NBANDS-1: b++, t=0, go to MAC. Otherwise go to OUT.
- OUT:
  - y←total clamped to [-2^(DW-1), 2^(DW-1)-1].
  - sat←1 if clamped, else 0.
  - out_valid←1 for one cycle; go to IDLE.
- Arithmetic shifts truncate toward −∞.
- Coefficient writes:
  - Accepted only when in_ready=1; dropped silently otherwise.
  - A write and an acceptance in the same IDLE cycle are both taken; the new coefficient is used for that sample.
- in_valid while in_ready=0 is ignored; no sample is buffered.
- Reset values:
  - in_ready=1, out_valid=0, y=0, sat=0.
  - Delay line, coefficients, latched gains and accumulators all 0.
- Reset asserted mid-operation: computation is aborted, no out_valid is issued, all state is cleared.

## Timing

- Acceptance at edge 0.
- MAC/GAIN steps run on edges 1..NBANDS*(NTAPS+1).
- OUT runs on edge L=NBANDS*(NTAPS+1)+1. out_valid and in_ready are both 1 in the cycle after edge L.
- Defaults: L=137; earliest next acceptance is edge 138; throughput is 1 sample per 138 cycles.
- gain may change freely after acceptance; only the latched copy is used.
- Coefficient write takes effect on the edge after coef_we is sampled.

## Configuration

- EQ_ROUND_EN defined:
  - Both shifts (>>>(CW-1) and >>>GFRAC) add 2^(shift-1) before shifting, giving round-half-up.
  - Latency is unchanged.
- EQ_ROUND_EN undefined: truncation toward −∞ as described above.

## Test plan

- Reset: assert rst mid-idle → in_ready=1, out_valid=0, y=0, sat=0; with all coefficients zero, x=0x1234 → y=0x0000 at edge 137.
- Single-tap impulse:
  - Setup: coef[0][0]=0x4000, gain[0]=0x1000, all other gains 0.
  - x=0x4000 → y=0x2000, sat=0, out_valid exactly 137 edges after acceptance.
  - Next x=0 → y=0.
- Delay tap:
  - Setup: coef[2][5]=0x7FFF, gain[2]=0x1000.
  - Samples 0x7FFF then 0,0,0,0,0 → y=0 for samples 1–5, y=0x7FFE on sample 6.
- Saturation:
  - Setup: coef[b][0]=0x7FFF and gain[b]=0x1000 for every band.
  - x=0x7FFF → y=0x7FFF, sat=1.
  - x=0x8000 → y=0x8000, sat=1.
- Handshake:
  - Hold in_valid=1 continuously → acceptances exactly 138 cycles apart.
  - coef_we during MAC → write dropped; output matches the old coefficient set.
- Abort: assert rst at edge 50 of a computation → no out_valid pulse, y=0; the following sample behaves as if the delay line were zero.
